// File: rtl/pc_sequencer.sv
// Next-PC controller: selects sequential/redirect/exception/eret targets each cycle,
// owns the mult/div busy counter that stalls HI/LO consumers, and flags bad fetch addresses.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO     = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI     = 32'h0000_6ffc,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        load_use,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] newpc,
    output logic        shall,
    output logic        flush,
    output logic        md_busy,
    output logic        pc_adel
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        MD_WAIT
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic [31:0] pc_plus4;
    logic        stall_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Once started the mult/div is committed: flush/exceptions never touch the count.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    md_cnt_d = md_is_div ? DIV_N : MULT_N;
                    state_d  = MD_WAIT;
                end
            end
            MD_WAIT: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    assign md_busy   = (state_q == MD_WAIT);
    assign stall_req = load_use | (md_use & md_busy);
    assign pc_plus4  = pc + 32'd4;

    // Redirect priority; a stalled branch/jump stays in D and re-asserts later.
    always_comb begin
        newpc = pc_plus4;
        shall = 1'b0;
        flush = 1'b0;
        if (reset) begin
            newpc = RESET_PC;
            flush = 1'b1;
        end else if (exc_req) begin
            newpc = EXC_VECTOR;
            flush = 1'b1;
        end else if (eret) begin
            newpc = epc;
            flush = 1'b1;
        end else if (stall_req) begin
            shall = 1'b1;
        end else if (jmp) begin
            newpc = jmp_target;
        end else if (br_taken) begin
            newpc = br_target;
        end
    end

    assign pc_adel = (pc[1:0] != 2'b00) | (pc < IMEM_LO) | (pc > IMEM_HI);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all against a
// cycle-indexed reference model (busy window tracked as an end-of-busy cycle number).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h3000;
    logic        br_taken = 1'b0, jmp = 1'b0, load_use = 1'b0;
    logic [31:0] br_target = '0, jmp_target = '0, epc = '0;
    logic        md_start = 1'b0, md_is_div = 1'b0, md_use = 1'b0;
    logic        exc_req = 1'b0, eret = 1'b0;
    logic [31:0] newpc;
    logic        shall, flush, md_busy, pc_adel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_end = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .load_use(load_use), .md_start(md_start), .md_is_div(md_is_div), .md_use(md_use),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .newpc(newpc), .shall(shall), .flush(flush), .md_busy(md_busy), .pc_adel(pc_adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; br_taken = 0; jmp = 0; load_use = 0; md_start = 0;
        md_is_div = 0; md_use = 0; exc_req = 0; eret = 0;
    endtask

    // Checks the current cycle's outputs, then advances the model across the posedge.
    task automatic step();
        logic        e_busy, e_sh, e_fl, e_adel;
        logic [31:0] e_pc, seq;
        #1;
        e_busy = (cyc < busy_end);
        seq    = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
        e_sh = 0; e_fl = 0; e_pc = seq;
        if (reset)                           begin e_pc = 32'h3000; e_fl = 1; end
        else if (exc_req)                    begin e_pc = 32'h4180; e_fl = 1; end
        else if (eret)                       begin e_pc = epc;      e_fl = 1; end
        else if (load_use || (md_use && e_busy)) e_sh = 1;
        else if (jmp)                        e_pc = jmp_target;
        else if (br_taken)                   e_pc = br_target;
        e_adel = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
        chk("newpc", newpc, e_pc);
        chk("shall", 32'(shall), 32'(e_sh));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("md_busy", 32'(md_busy), 32'(e_busy));
        chk("pc_adel", 32'(pc_adel), 32'(e_adel));
        @(posedge clk);
        if (reset) busy_end = 0;
        else if (!e_busy && md_start) busy_end = cyc + 1 + (md_is_div ? 10 : 5);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // reset two cycles, then sequential fetch
        idle(); reset = 1; pc = 32'h3000;
        step(); step();
        reset = 0; step();
        chk("post_reset_newpc", newpc, 32'h3004);
        // branch, then jmp beating branch
        pc = 32'h3010; br_taken = 1; br_target = 32'h3040; step();
        jmp = 1; jmp_target = 32'h3100; step();
        idle();
        // div then mult with a HI/LO consumer waiting in D
        for (int k = 0; k < 2; k++) begin
            pc = 32'h3200; md_start = 1; md_is_div = (k == 0); step();
            md_start = 0; md_use = 1;
            for (int i = 0; i < ((k == 0) ? 11 : 6); i++) step();
            idle();
        end
        // exception overrides load-use stall, then eret
        pc = 32'h3020; load_use = 1; exc_req = 1; step();
        idle(); eret = 1; epc = 32'h3024; step();
        idle();
        // exception during mult wait, then reset in the 3rd busy cycle
        pc = 32'h3300; md_start = 1; step();
        md_start = 0; step();
        exc_req = 1; step();
        exc_req = 0; step(); step(); step(); step();
        md_start = 1; step();
        md_start = 0; step(); step();
        reset = 1; step();
        reset = 0; step(); step();
        // fetch-address boundaries and pc+4 wrap
        pc = 32'h3002; step();
        pc = 32'h2ffc; step();
        pc = 32'h7000; step();
        pc = 32'h6ffc; step();
        pc = 32'hfffffffc; step();
        chk("wrap_newpc", newpc, 32'h0);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            pc         = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) << 2));
            br_taken   = ($urandom_range(0, 3) == 0);
            br_target  = $urandom;
            jmp        = ($urandom_range(0, 5) == 0);
            jmp_target = $urandom;
            load_use   = ($urandom_range(0, 7) == 0);
            md_start   = ($urandom_range(0, 5) == 0);
            md_is_div  = $urandom_range(0, 1) == 1;
            md_use     = ($urandom_range(0, 2) == 0);
            exc_req    = ($urandom_range(0, 11) == 0);
            eret       = ($urandom_range(0, 9) == 0);
            epc        = $urandom;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
